// File: rtl/mnist_img_loader_pkg.sv
// Shared constants and types for the MNIST image loader.
// Contents: image geometry, buffer address width, frame counter width, FSM state enum.
package mnist_pkg;

  localparam int unsigned NUM_PIXELS  = 784;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    FIRE      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mnist_img_loader_if.sv
// Pixel stream interface (valid/ready byte stream with end-of-frame marker).
// Signals: s_valid, s_data, s_last driven by the source; s_ready driven by the loader.
interface mnist_img_loader_if;
  import mnist_pkg::*;

  logic             s_valid;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/img_buf_ram.sv
// Image buffer: simple dual-port RAM, one write port and one registered read port.
// Ports: clk, rst_n (clears read register only), we/waddr/wdata write port,
//        raddr in / rdata out (1-cycle latency, 0 for raddr >= NUM_PIXELS).
module img_buf_ram
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [NUM_PIXELS];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; out-of-image addresses read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              rdata <= '0;
    else if (raddr < ADDR_W'(NUM_PIXELS))    rdata <= mem[raddr];
    else                                     rdata <= '0;
  end

endmodule

// File: rtl/mnist_img_loader.sv
// MNIST image loader: captures a 784-pixel frame from a byte stream, launches the
// accelerator with a one-cycle start pulse and serves pixel reads until acc_done.
// Ports: clk, rst_n, s (stream slave), rd_addr/rd_data (1-cycle read), start,
//        acc_done, busy, frame_err (pulse), frame_cnt (launched frames, wraps).
// Build option: IMG_LOADER_DBLBUF_EN enables ping-pong buffering.
module mnist_img_loader
  import mnist_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  mnist_img_loader_if.slave      s,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [PIX_W-1:0]       rd_data,
  output logic                   start,
  input  logic                   acc_done,
  output logic                   busy,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic                   drop_q, drop_d;
  logic                   ready_q, ready_d;
  logic                   start_d, busy_d, err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic                   xfer_c, we_c, frame_ok_c;
`ifdef IMG_LOADER_DBLBUF_EN
  logic                   pend_q, pend_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
`endif

  assign s.s_ready = ready_q;
  assign xfer_c    = s.s_valid && ready_q;

  // Framing, next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    drop_d      = drop_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q_w();
    we_c        = 1'b0;
    frame_ok_c  = 1'b0;
`ifdef IMG_LOADER_DBLBUF_EN
    pend_d      = pend_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
`endif

    // After a long frame, bytes are discarded through the next s_last.
    if (xfer_c) begin
      if (drop_q) begin
        if (s.s_last) drop_d = 1'b0;
      end else begin
        we_c = 1'b1;
        if (pix_cnt_q == LAST_PIX) begin
          pix_cnt_d = '0;
          if (s.s_last) begin
            frame_ok_c = 1'b1;
          end else begin
            err_d  = 1'b1;
            drop_d = 1'b1;
          end
        end else if (s.s_last) begin
          err_d     = 1'b1;
          pix_cnt_d = '0;
        end else begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        end
      end
    end

    case (state_q)
      LOAD:      if (frame_ok_c) state_d = FIRE;
      FIRE:      state_d = WAIT_DONE;
      WAIT_DONE: begin
`ifdef IMG_LOADER_DBLBUF_EN
        if (frame_ok_c) pend_d = 1'b1;
        if (acc_done) state_d = (pend_q || frame_ok_c) ? FIRE : LOAD;
`else
        if (acc_done) state_d = LOAD;
`endif
      end
      default:   state_d = LOAD;
    endcase

    if (state_d == FIRE) frame_cnt_d = frame_cnt + FRAME_CNT_W'(1);

`ifdef IMG_LOADER_DBLBUF_EN
    // Launch swaps the banks: the filled bank becomes the read bank.
    if (state_d == FIRE) begin
      pend_d    = 1'b0;
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
    end
    ready_d = (state_d == LOAD) || ((state_d == WAIT_DONE) && !pend_d);
`else
    ready_d = (state_d == LOAD);
`endif
    start_d = (state_d == FIRE);
    busy_d  = (state_d != LOAD);
  end

  function automatic logic [FRAME_CNT_W-1:0] frame_cnt_q_w();
    return frame_cnt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      pix_cnt_q <= '0;
      drop_q    <= 1'b0;
      ready_q   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
`ifdef IMG_LOADER_DBLBUF_EN
      pend_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      drop_q    <= drop_d;
      ready_q   <= ready_d;
      start     <= start_d;
      busy      <= busy_d;
      frame_err <= err_d;
      frame_cnt <= frame_cnt_d;
`ifdef IMG_LOADER_DBLBUF_EN
      pend_q    <= pend_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
`endif
    end
  end

`ifdef IMG_LOADER_DBLBUF_EN
  logic [PIX_W-1:0] rdata0, rdata1;

  img_buf_ram u_buf0 (
    .clk(clk), .rst_n(rst_n), .we(we_c && !wr_bank_q), .waddr(pix_cnt_q),
    .wdata(s.s_data), .raddr(rd_addr), .rdata(rdata0)
  );
  img_buf_ram u_buf1 (
    .clk(clk), .rst_n(rst_n), .we(we_c && wr_bank_q), .waddr(pix_cnt_q),
    .wdata(s.s_data), .raddr(rd_addr), .rdata(rdata1)
  );

  assign rd_data = rd_bank_q ? rdata1 : rdata0;
`else
  img_buf_ram u_buf (
    .clk(clk), .rst_n(rst_n), .we(we_c), .waddr(pix_cnt_q),
    .wdata(s.s_data), .raddr(rd_addr), .rdata(rd_data)
  );
`endif

endmodule

// File: doc/mnist_img_loader.md
Name: mnist_img_loader

Overview:
- Upstream stage of the MNIST accelerator top.
- Accepts a 784-pixel 8-bit image as a valid/ready byte stream and stores it in an on-chip image buffer.
- Once a complete, well-framed image is held, issues a one-cycle start pulse to the accelerator and serves pixel reads over a synchronous read port.
- Holds the image stable until the accelerator reports done, then rearms for the next frame.

Parameters:
- NUM_PIXELS, 784, pixels per image (28x28).
- PIX_W, 8, pixel width in bits.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= NUM_PIXELS.

Ports:
- clk  in  1  system clock (25 MHz target).
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input pixel valid.
- s_data  in  PIX_W  input pixel value.
- s_last  in  1  marks final pixel of a frame.
- s_ready  out  1  loader accepts a pixel this cycle.
- rd_addr  in  ADDR_W  accelerator pixel read address.
- rd_data  out  PIX_W  pixel at rd_addr; 1-cycle read latency.
- start  out  1  one-cycle pulse to accelerator.
- acc_done  in  1  accelerator inference complete (level or pulse).
- busy  out  1  image committed, inference in flight.
- frame_err  out  1  one-cycle pulse on framing error.
- frame_cnt  out  16  count of frames successfully launched; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: s_ready=0, start=0, busy=0, frame_err=0, frame_cnt=0, rd_data=0, pix_cnt=0, state=LOAD.
  - s_ready rises the first cycle after rst_n deasserts.
- Buffer contents are not reset.
- A transfer occurs on a rising clk edge when s_valid && s_ready. Write address = pix_cnt; pix_cnt increments per transfer.
- FSM states: LOAD, FIRE, WAIT_DONE.
- LOAD:
  - s_ready=1.
  - Transfer at pix_cnt=NUM_PIXELS-1 with s_last=1 -> FIRE; pix_cnt cleared.
  - Transfer with s_last=1 at pix_cnt<NUM_PIXELS-1 (short frame) -> frame_err pulse; pix_cnt=0; stay in LOAD; the partial frame is discarded.
  - Transfer at pix_cnt=NUM_PIXELS-1 with s_last=0 (long frame) -> frame_err pulse; pix_cnt=0; stay in LOAD. Subsequent bytes up to and including the next s_last are dropped (drop flag); the next frame starts after that s_last.
- FIRE:
  - s_ready=0, start=1 for exactly one cycle, busy=1, frame_cnt+=1.
  - Always goes to WAIT_DONE next cycle.
- WAIT_DONE:
  - s_ready=0, busy=1, start=0.
  - acc_done=1 -> LOAD next cycle; busy=0 in that cycle.
- Latency: last pixel accepted at edge N -> start high during cycle N+1.
- acc_done asserted outside WAIT_DONE is ignored.
- rd_data is a registered buffer read, valid in all states. Reads during LOAD return possibly partial data; this is not an error.
- rd_addr >= NUM_PIXELS returns 0.
- Reset mid-frame or mid-inference: everything returns to reset values immediately; no start is issued; the partial frame is lost.

Optional Feature:
- Macro: IMG_LOADER_DBLBUF_EN.
- Defined:
  - Two buffer banks (ping-pong). Write bank and read bank toggle at FIRE.
  - s_ready remains 1 in WAIT_DONE while the write bank is not full.
  - If a complete frame is captured during WAIT_DONE, it is held pending (s_ready=0). On acc_done the FSM goes directly to FIRE, giving back-to-back inference.
  - rd_data always reads the bank last launched.
- Undefined: single bank, behaviour exactly as above.

Decomposition:
- Package mnist_pkg: NUM_PIXELS, PIX_W, ADDR_W, state enum (LOAD/FIRE/WAIT_DONE), frame_cnt width.
- Sub-module img_buf_ram: simple dual-port RAM, one write port and one registered read port, inferable as BRAM.
  - Instantiated once, or twice under IMG_LOADER_DBLBUF_EN.

Test Plan:
1. Reset release, then stream 784 pixels (value = index mod 256) with s_last on the 784th -> start pulses once, 1 cycle after the last transfer; busy=1; frame_cnt=1; rd_addr=300 returns 0x2C.
2. Stream 784 pixels with random s_valid gaps at 30% duty -> identical buffer contents and a single start pulse; s_ready never drops in LOAD.
3. Short frame: s_last on pixel 500 -> frame_err pulse, no start. A following good 784-pixel frame launches with frame_cnt=1.
4. Long frame: 784 pixels with s_last=0, then 10 extra bytes ending in s_last -> one frame_err pulse, extras dropped, no start. The next good frame launches normally.
5. During WAIT_DONE, drive s_valid=1 -> s_ready=0, no writes. Pulse acc_done -> busy falls and s_ready rises next cycle.
6. Assert rst_n low at pixel 400 and again during WAIT_DONE -> all outputs return to 0 asynchronously; no start is issued. A subsequent full frame launches correctly.
